// File: rtl/norm2_pkg.sv
// Shared constants and constant functions for the norm2 multiplier pipeline.
package norm2_pkg;

  localparam int NORM2_MIN_STAGE = 1;
  localparam int NORM2_MAX_STAGE = 6;
  localparam int NORM2_MAX_W     = 130;

  function automatic int norm2_pw(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic logic signed [NORM2_MAX_W-1:0] norm2_sat_hi(input int dw);
    logic signed [NORM2_MAX_W-1:0] one;
    one = NORM2_MAX_W'(1);
    return (one <<< (dw - 1)) - one;
  endfunction

  function automatic logic signed [NORM2_MAX_W-1:0] norm2_sat_lo(input int dw);
    logic signed [NORM2_MAX_W-1:0] one;
    one = NORM2_MAX_W'(1);
    return -(one <<< (dw - 1));
  endfunction

endpackage

// File: rtl/norm2_pipe_reg.sv
// One pipeline slot: data register with enable, valid bit with synchronous clear.
module norm2_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         vld_in,
  input  logic [W-1:0] d,
  output logic         vld_out,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out <= 1'b0;
    end else if (en) begin
      vld_out <= vld_in;
    end
  end

  // Data is never reset; its value is meaningless while the valid bit is low.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/norm2_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control.
// Define NORM2_MUL_SAT_EN to saturate the narrowed product and report a sticky ovf.
module norm2_mul_pipe
  import norm2_pkg::*;
#(
  parameter int DIN0_WIDTH  = 9,
  parameter int DIN1_WIDTH  = 45,
  parameter int DOUT_WIDTH  = 52,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_last,
  output logic                  ovf
);

  localparam int PW = norm2_pw(DIN0_WIDTH, DIN1_WIDTH);

  if (NUM_STAGE < NORM2_MIN_STAGE || NUM_STAGE > NORM2_MAX_STAGE) begin : g_bad_stage
    $error("norm2_mul_pipe: NUM_STAGE out of range");
  end
  if (DIN0_WIDTH < 2 || DIN0_WIDTH > 64 || DIN1_WIDTH < 2 || DIN1_WIDTH > 64) begin : g_bad_din
    $error("norm2_mul_pipe: operand width out of range");
  end
  if (DOUT_WIDTH < 2 || DOUT_WIDTH > DIN0_WIDTH + DIN1_WIDTH + 1) begin : g_bad_dout
    $error("norm2_mul_pipe: DOUT_WIDTH out of range");
  end

  logic stall;
  logic en;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ap_rst | ~stall;

  // Stage 1 input: extend each operand by one bit and form the full product.
  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod;

  assign a_ext = (DIN0_SIGNED != 0) ? {din0[DIN0_WIDTH-1], din0} : {1'b0, din0};
  assign b_ext = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
  assign prod  = PW'(a_ext) * PW'(b_ext);

  logic [PW:0] data_p [NUM_STAGE];
  logic        vld_p  [NUM_STAGE];

  assign data_p[0] = {in_last, prod};
  assign vld_p[0]  = in_valid;

  // Stages 1..NUM_STAGE-1: pure delay of the full-width product.
  for (genvar i = 1; i < NUM_STAGE; i++) begin : g_stage
    norm2_pipe_reg #(.W(PW + 1)) u_reg (
      .clk     (ap_clk),
      .rst     (ap_rst),
      .en      (en),
      .vld_in  (vld_p[i-1]),
      .d       (data_p[i-1]),
      .vld_out (vld_p[i]),
      .q       (data_p[i])
    );
  end

  // Last stage: narrow or widen the product to DOUT_WIDTH.
  logic signed [PW-1:0]   prod_last;
  logic                   last_last;
  logic [DOUT_WIDTH:0]    fmt_p;
  logic                   fmt_sat;
  logic [DOUT_WIDTH-1:0]  fmt_val;

  assign prod_last = data_p[NUM_STAGE-1][PW-1:0];
  assign last_last = data_p[NUM_STAGE-1][PW];
  assign fmt_sat   = fmt_p[DOUT_WIDTH];
  assign fmt_val   = fmt_p[DOUT_WIDTH-1:0];

  if (PW > DOUT_WIDTH) begin : g_reduce
`ifdef NORM2_MUL_SAT_EN
    localparam logic signed [PW-1:0] HI = PW'(norm2_sat_hi(DOUT_WIDTH));
    localparam logic signed [PW-1:0] LO = PW'(norm2_sat_lo(DOUT_WIDTH));

    function automatic logic [DOUT_WIDTH:0] reduce(input logic signed [PW-1:0] p);
      if (p > HI) return {1'b1, HI[DOUT_WIDTH-1:0]};
      if (p < LO) return {1'b1, LO[DOUT_WIDTH-1:0]};
      return {1'b0, p[DOUT_WIDTH-1:0]};
    endfunction
`else
    function automatic logic [DOUT_WIDTH:0] reduce(input logic signed [PW-1:0] p);
      return {1'b0, p[DOUT_WIDTH-1:0]};
    endfunction
`endif
    assign fmt_p = reduce(prod_last);
  end else begin : g_extend
    function automatic logic [DOUT_WIDTH:0] extend(input logic signed [PW-1:0] p);
      return {1'b0, DOUT_WIDTH'(p)};
    endfunction
    assign fmt_p = extend(prod_last);
  end

  norm2_pipe_reg #(.W(DOUT_WIDTH + 1)) u_out (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .en      (en),
    .vld_in  (vld_p[NUM_STAGE-1]),
    .d       ({last_last, fmt_val}),
    .vld_out (out_valid),
    .q       ({out_last, dout})
  );

  // Sticky flag rises together with out_valid of the clamped result.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ovf <= 1'b0;
    end else if (en && vld_p[NUM_STAGE-1] && fmt_sat) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_norm2_mul_pipe.sv
// Scoreboard bench for norm2_mul_pipe: driver pushes expectations, monitor pops on output.
module tb_norm2_mul_pipe;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        ap_rst;
  logic        in_valid, in_ready, in_last;
  logic [8:0]  din0;
  logic [44:0] din1;
  logic        out_valid, out_ready, out_last, ovf;
  logic [51:0] dout;

  logic        v2_in_valid, v2_in_ready, v2_in_last;
  logic [7:0]  v2_din0, v2_din1;
  logic        v2_out_valid, v2_out_last, v2_ovf;
  logic [16:0] v2_dout;

  norm2_mul_pipe dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_last(out_last), .ovf(ovf)
  );

  norm2_mul_pipe #(
    .DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(17), .NUM_STAGE(1),
    .DIN0_SIGNED(0), .DIN1_SIGNED(0)
  ) dut2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(v2_in_valid), .in_ready(v2_in_ready),
    .din0(v2_din0), .din1(v2_din1), .in_last(v2_in_last),
    .out_valid(v2_out_valid), .out_ready(1'b1),
    .dout(v2_dout), .out_last(v2_out_last), .ovf(v2_ovf)
  );

  typedef struct {
    logic [51:0] d;
    logic        l;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

`ifdef NORM2_MUL_SAT_EN
  localparam logic [51:0] SAT_EXP = 52'h8_0000_0000_0000;
  localparam logic        OVF_EXP = 1'b1;
`else
  localparam logic [51:0] SAT_EXP = 52'd256;
  localparam logic        OVF_EXP = 1'b0;
`endif

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every delivered result must match the head of the queue.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got %0h want none", dout);
      end else begin
        m_e = q.pop_front();
        chk("dout", 64'(dout), 64'(m_e.d));
        chk("out_last", 64'(out_last), 64'(m_e.l));
        if (m_e.lat) chk("latency", 64'(cyc - m_e.acc), 64'd3);
      end
    end
  end

  task automatic send(input logic [8:0] a, input logic [44:0] b, input logic l,
                      input logic [51:0] e, input bit lat, input bit rdy_chk);
    int n;
    exp_t x;
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    in_last  = l;
    n = 0;
    @(negedge ap_clk);
    if (rdy_chk) chk("in_ready", 64'(in_ready), 64'd1);
    while (!in_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
    end else begin
      x.d = e; x.l = l; x.acc = cyc; x.lat = lat;
      q.push_back(x);
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [51:0] held_d;
    logic        held_l;
    longint      sa, sb;

    ap_rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
    out_ready = 1'b1;
    v2_in_valid = 1'b0; v2_in_last = 1'b0; v2_din0 = '0; v2_din1 = '0;

    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_out_valid2", 64'(v2_out_valid), 64'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // -3 * 5
    send(9'h1FD, 45'd5, 1'b1, 52'hF_FFFF_FFFF_FFF1, 1'b1, 1'b1);
    drain();

    // Back-to-back stream of 20.
    for (int i = 0; i < 20; i++) begin
      sa = longint'(i - 10);
      sb = longint'(i * 1000 + 7);
      send(9'(sa), 45'(sb), i[0], 52'(sa * sb), 1'b1, 1'b1);
    end
    drain();
    chk("ovf_clean", 64'(ovf), 64'd0);

    // Fill the pipeline with out_ready low, then hold for 5 cycles.
    out_ready = 1'b0;
    send(9'd7, 45'd3, 1'b1, 52'd21, 1'b0, 1'b0);
    send(9'h1FF, 45'd1, 1'b0, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send(9'd0, 45'h1FFF_FFFF_FFFF, 1'b1, 52'd0, 1'b0, 1'b0);
    @(negedge ap_clk);
    held_d = dout;
    held_l = out_last;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_head", 64'(held_d), 64'd21);
    for (int j = 0; j < 5; j++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_dout", 64'(dout), 64'(held_d));
      chk("stall_last", 64'(out_last), 64'(held_l));
      @(negedge ap_clk);
    end
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Most-negative din0 times zero, zero times max din1.
    send(9'h100, 45'd0, 1'b0, 52'd0, 1'b1, 1'b1);
    send(9'd0, 45'h1FFF_FFFF_FFFF, 1'b1, 52'd0, 1'b1, 1'b1);
    drain();
    chk("ovf_zero_ops", 64'(ovf), 64'd0);

    // -256 * (2^45-1): out of range for 52 bits.
    send(9'h100, 45'h1FFF_FFFF_FFFF, 1'b1, SAT_EXP, 1'b1, 1'b1);
    drain();
    chk("ovf_set", 64'(ovf), 64'(OVF_EXP));
    send(9'h1FD, 45'd5, 1'b0, 52'hF_FFFF_FFFF_FFF1, 1'b1, 1'b1);
    drain();
    chk("ovf_sticky", 64'(ovf), 64'(OVF_EXP));

    // Reset with 3 transactions in flight.
    out_ready = 1'b0;
    send(9'd1, 45'd1, 1'b1, 52'd1, 1'b0, 1'b0);
    send(9'd2, 45'd2, 1'b0, 52'd4, 1'b0, 1'b0);
    send(9'd3, 45'd3, 1'b1, 52'd9, 1'b0, 1'b0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_ovf", 64'(ovf), 64'd0);
    send(9'h1FD, 45'd5, 1'b1, 52'hF_FFFF_FFFF_FFF1, 1'b1, 1'b1);
    drain();
    repeat (4) @(negedge ap_clk);

    // Unsigned 8x8, single stage: 255*255.
    @(posedge ap_clk);
    #1;
    v2_in_valid = 1'b1; v2_din0 = 8'd255; v2_din1 = 8'd255; v2_in_last = 1'b1;
    @(negedge ap_clk);
    chk("u8_in_ready", 64'(v2_in_ready), 64'd1);
    @(posedge ap_clk);
    #1;
    v2_in_valid = 1'b0;
    @(negedge ap_clk);
    chk("u8_out_valid", 64'(v2_out_valid), 64'd1);
    chk("u8_dout", 64'(v2_dout), 64'd65025);
    chk("u8_out_last", 64'(v2_out_last), 64'd1);
    @(negedge ap_clk);
    chk("u8_out_valid_off", 64'(v2_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
